// File: rtl/can_bus_fabric.sv
// N-node wired-AND CAN bus model with per-node isolation, propagation delay, fault forcing,
// idle/SOF detection, frame counting and stuck-dominant detection.
module can_bus_fabric #(
  parameter int unsigned NUM_NODES      = 2,
  parameter int unsigned DELAY_CYCLES   = 0,
  parameter int unsigned BIT_CYCLES     = 100,
  parameter int unsigned IDLE_BITS      = 11,
  parameter int unsigned DOM_LIMIT_BITS = 12
) (
  input  logic                 clk_sys,
  input  logic                 rst,
  input  logic [NUM_NODES-1:0] can_txd,
  output logic [NUM_NODES-1:0] can_rxd,
  input  logic [NUM_NODES-1:0] connect_en,
  input  logic [1:0]           fault_mode,
  input  logic                 err_clr,
  output logic                 bus_level,
  output logic                 bus_idle,
  output logic                 sof_pulse,
  output logic [15:0]          frame_cnt,
  output logic                 err_stuck_dom
);

  localparam int unsigned RecMax = IDLE_BITS * BIT_CYCLES;
  localparam int unsigned DomMax = DOM_LIMIT_BITS * BIT_CYCLES;
  localparam int unsigned RecW   = $clog2(RecMax + 1);
  localparam int unsigned DomW   = $clog2(DomMax + 1);

  logic raw_bus;
  logic bus_faulted;

  always_comb begin
    raw_bus = 1'b1;
    for (int unsigned i = 0; i < NUM_NODES; i++) begin
      if (connect_en[i] && !can_txd[i]) raw_bus = 1'b0;
    end
    unique case (fault_mode)
      2'b01:   bus_faulted = 1'b0;
      2'b10:   bus_faulted = 1'b1;
      default: bus_faulted = raw_bus;
    endcase
  end

  generate
    if (DELAY_CYCLES == 0) begin : g_nodly
      assign bus_level = bus_faulted;
    end else begin : g_dly
      logic [DELAY_CYCLES-1:0] dly_q, dly_d;
      always_comb dly_d = (dly_q << 1) | DELAY_CYCLES'(bus_faulted);
      always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) dly_q <= '1;
        else     dly_q <= dly_d;
      end
      assign bus_level = dly_q[DELAY_CYCLES-1];
    end
  endgenerate

  // Isolated nodes hear only their own transmitter.
  always_comb can_rxd = (connect_en & {NUM_NODES{bus_level}}) | (~connect_en & can_txd);

  logic [RecW-1:0] rec_cnt_q, rec_cnt_d;
  logic [DomW-1:0] dom_cnt_q, dom_cnt_d;
  logic            bus_prev_q, bus_prev_d;
  logic            bus_idle_q, bus_idle_d;
  logic            sof_q, sof_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            err_q, err_d;
  logic            sof_det;

  always_comb begin
    rec_cnt_d = rec_cnt_q;
    dom_cnt_d = dom_cnt_q;
    if (bus_level) begin
      dom_cnt_d = '0;
      if (rec_cnt_q != RecW'(RecMax)) rec_cnt_d = rec_cnt_q + 1'b1;
    end else begin
      rec_cnt_d = '0;
      if (dom_cnt_q != DomW'(DomMax)) dom_cnt_d = dom_cnt_q + 1'b1;
    end

    bus_idle_d = bus_idle_q;
    if (!bus_level)                         bus_idle_d = 1'b0;
    else if (rec_cnt_q == RecW'(RecMax))    bus_idle_d = 1'b1;

    sof_det     = bus_prev_q && !bus_level && bus_idle_q;
    sof_d       = sof_det;
    frame_cnt_d = sof_det ? frame_cnt_q + 16'd1 : frame_cnt_q;
    bus_prev_d  = bus_level;

    // Set beats clear when both happen at the same edge.
    if (dom_cnt_q == DomW'(DomMax)) err_d = 1'b1;
    else if (err_clr)               err_d = 1'b0;
    else                            err_d = err_q;
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      rec_cnt_q   <= '0;
      dom_cnt_q   <= '0;
      bus_prev_q  <= 1'b1;
      bus_idle_q  <= 1'b0;
      sof_q       <= 1'b0;
      frame_cnt_q <= 16'h0000;
      err_q       <= 1'b0;
    end else begin
      rec_cnt_q   <= rec_cnt_d;
      dom_cnt_q   <= dom_cnt_d;
      bus_prev_q  <= bus_prev_d;
      bus_idle_q  <= bus_idle_d;
      sof_q       <= sof_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  assign bus_idle      = bus_idle_q;
  assign sof_pulse     = sof_q;
  assign frame_cnt     = frame_cnt_q;
  assign err_stuck_dom = err_q;

endmodule

// File: tb/tb_can_bus_fabric.sv
// Scoreboard bench: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_can_bus_fabric;
  localparam int N = 4;
  localparam int MRXD = 1, MBUS = 2, MIDLE = 4, MSOF = 8, MCNT = 16, MERR = 32;
  localparam int MBUS3 = 64, MRXD3 = 128, MCNT3 = 256;

  logic         clk_sys = 1'b1;
  logic         rst;
  logic [N-1:0] can_txd, connect_en, rxd0, rxd3;
  logic [1:0]   fault_mode;
  logic         err_clr;
  logic         bus0, idle0, sof0, err0, bus3, idle3, sof3, err3;
  logic [15:0]  cnt0, cnt3;

  always #5 clk_sys = ~clk_sys;

  can_bus_fabric #(.NUM_NODES(N), .DELAY_CYCLES(0), .BIT_CYCLES(10), .IDLE_BITS(11),
                   .DOM_LIMIT_BITS(12)) dut0 (
    .clk_sys(clk_sys), .rst(rst), .can_txd(can_txd), .can_rxd(rxd0), .connect_en(connect_en),
    .fault_mode(fault_mode), .err_clr(err_clr), .bus_level(bus0), .bus_idle(idle0),
    .sof_pulse(sof0), .frame_cnt(cnt0), .err_stuck_dom(err0)
  );

  can_bus_fabric #(.NUM_NODES(N), .DELAY_CYCLES(3), .BIT_CYCLES(10), .IDLE_BITS(11),
                   .DOM_LIMIT_BITS(12)) dut3 (
    .clk_sys(clk_sys), .rst(rst), .can_txd(can_txd), .can_rxd(rxd3), .connect_en(connect_en),
    .fault_mode(fault_mode), .err_clr(err_clr), .bus_level(bus3), .bus_idle(idle3),
    .sof_pulse(sof3), .frame_cnt(cnt3), .err_stuck_dom(err3)
  );

  typedef struct packed {
    logic [8:0]  mask;
    logic [3:0]  rxd;
    logic        bus;
    logic        idle;
    logic        sof;
    logic [15:0] cnt;
    logic        err;
    logic        bus3;
    logic [3:0]  rxd3;
    logic [15:0] cnt3;
  } exp_t;

  exp_t  q_e[$];
  string q_n[$];
  int    checks = 0;
  int    failures = 0;

  function automatic exp_t mk(input int m, input int rxd, input int bus, input int idle,
                              input int sof, input int cnt, input int err, input int b3,
                              input int r3, input int c3);
    mk.mask = 9'(m);   mk.rxd = 4'(rxd); mk.bus = 1'(bus);  mk.idle = 1'(idle);
    mk.sof  = 1'(sof); mk.cnt = 16'(cnt); mk.err = 1'(err); mk.bus3 = 1'(b3);
    mk.rxd3 = 4'(r3);  mk.cnt3 = 16'(c3);
  endfunction

  function automatic exp_t none();
    none = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic cmp(input string nm, input string fld, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, exp);
    end
  endtask

  task automatic cyc(input string nm, input exp_t e);
    q_e.push_back(e);
    q_n.push_back(nm);
    @(posedge clk_sys);
    #1;
  endtask

  always @(negedge clk_sys) begin : mon
    exp_t  e;
    string nm;
    if (q_e.size() > 0) begin
      e  = q_e.pop_front();
      nm = q_n.pop_front();
      if (e.mask[0]) cmp(nm, "can_rxd",       16'(rxd0),  16'(e.rxd));
      if (e.mask[1]) cmp(nm, "bus_level",     16'(bus0),  16'(e.bus));
      if (e.mask[2]) cmp(nm, "bus_idle",      16'(idle0), 16'(e.idle));
      if (e.mask[3]) cmp(nm, "sof_pulse",     16'(sof0),  16'(e.sof));
      if (e.mask[4]) cmp(nm, "frame_cnt",     cnt0,       e.cnt);
      if (e.mask[5]) cmp(nm, "err_stuck_dom", 16'(err0),  16'(e.err));
      if (e.mask[6]) cmp(nm, "bus_level_d3",  16'(bus3),  16'(e.bus3));
      if (e.mask[7]) cmp(nm, "can_rxd_d3",    16'(rxd3),  16'(e.rxd3));
      if (e.mask[8]) cmp(nm, "frame_cnt_d3",  cnt3,       e.cnt3);
    end
  end

  initial begin
    rst = 1'b1; can_txd = '1; connect_en = '1; fault_mode = 2'b00; err_clr = 1'b0;
    for (int i = 0; i < 2; i++) cyc("reset", mk(511, 15, 1, 0, 0, 0, 0, 1, 15, 0));
    rst = 1'b0;

    // Node 2 dominant for 5 cycles; the 3-stage instance sees it 3 cycles late.
    for (int j = 0; j < 10; j++) begin
      logic b0, b3;
      can_txd = (j < 5) ? 4'b1011 : 4'b1111;
      b0 = (j >= 5);
      b3 = !(j >= 3 && j <= 7);
      cyc("dom5", mk(MRXD | MBUS | MIDLE | MSOF | MBUS3 | MRXD3, {4{b0}}, b0, 0, 0, 0, 0,
                     b3, {4{b3}}, 0));
    end

    connect_en = 4'b1110; can_txd = 4'b1110;
    for (int i = 0; i < 3; i++)
      cyc("isolate", mk(MRXD | MBUS | MBUS3 | MRXD3, 4'b1110, 1, 0, 0, 0, 0, 1, 4'b1110, 0));
    connect_en = '1; can_txd = '1;
    cyc("reconnect", mk(MRXD | MBUS | MIDLE, 15, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 9; k < 110; k++) cyc("", none());
    cyc("idle_pre", mk(MIDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("idle_set", mk(MIDLE, 0, 0, 1, 0, 0, 0, 0, 0, 0));

    can_txd = 4'b1110;
    cyc("sof_edge", mk(MBUS | MIDLE | MSOF | MCNT, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    can_txd = '1;
    cyc("sof_pulse", mk(MBUS | MIDLE | MSOF | MCNT, 0, 1, 0, 1, 1, 0, 0, 0, 0));
    cyc("sof_end", mk(MSOF | MCNT, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    can_txd = 4'b1110;
    cyc("inframe_dom", mk(MBUS | MSOF | MCNT, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    can_txd = '1;
    cyc("inframe_nopulse", mk(MSOF | MCNT | MCNT3, 0, 0, 0, 0, 1, 0, 0, 0, 1));

    force dut0.frame_cnt_d = 16'hffff;
    cyc("", none());
    release dut0.frame_cnt_d;
    cyc("wrap_preload", mk(MSOF | MCNT, 0, 0, 0, 0, 16'hffff, 0, 0, 0, 0));
    for (int k = 3; k < 111; k++) cyc("", none());
    cyc("wrap_idle", mk(MIDLE | MCNT, 0, 0, 1, 0, 16'hffff, 0, 0, 0, 0));
    can_txd = 4'b1110;
    cyc("wrap_edge", mk(MBUS, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    can_txd = '1;
    cyc("wrap_sof", mk(MSOF | MCNT, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    fault_mode = 2'b01;
    cyc("fault_dom", mk(MRXD | MBUS, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int m = 1; m < 120; m++)
      cyc((m == 3) ? "fault_delayed" : "", mk((m == 3) ? (MBUS3 | MCNT3) : 0,
                                              0, 0, 0, 0, 0, 0, 0, 0, 2));
    cyc("stuck_pre", mk(MERR, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("stuck_set", mk(MERR, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    err_clr = 1'b1;
    cyc("clr_held", mk(MERR, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    err_clr = 1'b0;
    cyc("clr_while_fault", mk(MERR, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    fault_mode = 2'b00;
    cyc("fault_release", mk(MBUS | MERR, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    err_clr = 1'b1;
    cyc("clr_pre", mk(MERR, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    err_clr = 1'b0; fault_mode = 2'b10; can_txd = '0;
    cyc("clr_done_force_rec", mk(MERR | MRXD | MBUS, 15, 1, 0, 0, 0, 0, 0, 0, 0));
    fault_mode = 2'b00; can_txd = '1;
    cyc("", none());

    fault_mode = 2'b01;
    for (int m = 0; m < 121; m++) cyc("", none());
    cyc("pre_reset", mk(MERR | MCNT3, 0, 0, 0, 0, 0, 1, 0, 0, 2));
    rst = 1'b1;
    cyc("async_reset", mk(MERR | MIDLE | MSOF | MCNT | MBUS3 | MRXD3 | MCNT3,
                          0, 0, 0, 0, 0, 0, 1, 15, 0));
    rst = 1'b0; fault_mode = 2'b00;
    cyc("", none());

    @(negedge clk_sys);
    #1;
    cmp("drain", "pending", 16'(q_e.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
